id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, datapath width.
REQ-002 The block SHALL have parameter CMD_W, default 4, ALU command width.
REQ-003 clk  in  1  pipeline clock, all state updates on posedge.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 flush  in  1  branch taken; kill instruction entering EX.
REQ-006 id_valid, id_wb_en, id_mem_r, id_mem_w, id_uses_src2  in  1 each  ID-stage control.
REQ-007 id_src1, id_src2, id_dest  in  5 each  ID register addresses.
REQ-008 id_reg1, id_reg2, id_imm, id_pc  in  DATA_W each  register-file read data, immediate, PC.
REQ-009 id_alu_cmd  in  CMD_W  ALU command.
REQ-010 mem_dest  in  5, mem_wb_en  in  1, mem_alu_res  in  DATA_W  EX/MEM-stage result.
REQ-011 wb_dest  in  5, wb_en  in  1, wb_val  in  DATA_W  MEM/WB writeback (also drives register-file write, negedge).
REQ-012 stall  out  1  freeze PC and IF/ID register.
REQ-013 ex_valid, ex_wb_en, ex_mem_r, ex_mem_w  out  1 each; ex_dest  out  5; ex_alu_cmd  out  CMD_W.
REQ-014 ex_pc, ex_imm, ex_val1, ex_val2  out  DATA_W each  operands to EX (val2 is also store data).
REQ-015 stall_cnt  out  32  count of stall cycles.

Function
REQ-016 On each posedge, when not stalled and not flushed, all id_* fields SHALL be registered into the ex_* state (including src1/src2 copies); latency ID->EX exactly 1 cycle.
REQ-017 Load-use hazard: hazard SHALL be true iff id_valid & ex_valid & ex_mem_r & ex_wb_en & ex_dest!=0 & (ex_dest==id_src1 | (id_uses_src2 & ex_dest==id_src2)).
REQ-018 stall SHALL equal hazard & !flush (combinational).
REQ-019 When stall=1 the block SHALL load a bubble: ex_valid, ex_wb_en, ex_mem_r, ex_mem_w=0, other fields don't-care.
REQ-020 When flush=1 the block SHALL load a bubble regardless of hazard; flush dominates stall.
REQ-021 Forwarding on ex_val1 (same for ex_val2 with src2): if mem_wb_en & mem_dest!=0 & mem_dest==ex_src1 -> mem_alu_res; else if wb_en & wb_dest!=0 & wb_dest==ex_src1 -> wb_val; else registered reg1; combinational from registered state.
REQ-022 Register 0 SHALL never be forwarded or cause a stall.
REQ-023 stall_cnt SHALL increment by 1 each posedge with stall=1 and saturate at 0xFFFF_FFFF.
REQ-024 No RAW hazard against WB-stage SHALL stall; negedge register-file write makes same-cycle read valid.

Reset
REQ-025 While rst=1 all ex_* outputs, stored src1/src2, and stall_cnt SHALL be 0; ex_valid=0 immediately (asynchronous).
REQ-026 rst asserted mid-stall SHALL clear state; first posedge after release SHALL capture ID normally.

Configuration
REQ-027 Macro ID_EX_FWD_EN defined: REQ-017 and REQ-021 apply as written.
REQ-028 Macro ID_EX_FWD_EN undefined: no forwarding muxes (ex_val1/2 = registered reg1/reg2); hazard SHALL also be true for any RAW against EX (ex_valid & ex_wb_en) or MEM (mem_wb_en) destination, non-zero, loads or not.

Structure
REQ-029 Package mips_pkg SHALL hold REG_ADDR_W=5, DATA_W, CMD_W, and the ALU command enum.
REQ-030 Hazard logic SHALL be a combinational sub-module hazard_detect; pipeline register and forwarding muxes stay in id_ex_stage.

Verification
REQ-031 ID add r3,r1,r2 (reg1=5, reg2=7), no hazards -> next cycle ex_valid=1, ex_dest=3, ex_val1=5, ex_val2=7.
REQ-032 EX holds lw r4; ID add r5,r4,r1 -> stall=1 one cycle, bubble in EX, stall_cnt 0->1; next cycle add captured, ex_val1 = wb_val when wb_dest=4.
REQ-033 mem_dest=2 mem_alu_res=0xAA, wb_dest=2 wb_val=0xBB, ex_src2=2 -> ex_val2=0xAA (MEM priority); with mem_wb_en=0 -> 0xBB.
REQ-034 mem_dest=0 mem_wb_en=1 mem_alu_res=0x55, ex_src1=0, reg1=0 -> ex_val1=0; lw r0 in EX with ID using r0 -> stall=0.
REQ-035 Load-use hazard and flush same cycle -> stall=0, EX bubble, stall_cnt unchanged.
REQ-036 rst pulse between clock edges during stall -> ex_valid=0, stall_cnt=0 before next posedge; ID_EX_FWD_EN undefined build: ID add r6,r7,r0 with mem_dest=7 mem_wb_en=1 -> stall=1.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline slice: register-address width,
// default datapath/command widths, ALU command encoding and the register
// match helpers used by both hazard detection and operand forwarding.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int CMD_W      = 4;

  typedef enum logic [CMD_W-1:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_OR  = 4'h3,
    ALU_XOR = 4'h4,
    ALU_SLT = 4'h5,
    ALU_SLL = 4'h6,
    ALU_SRL = 4'h7,
    ALU_NOP = 4'hF
  } alu_cmd_e;

  // True when a writer to 'dest' feeds one of the consumer's sources.
  // r0 is hard-wired zero, so it never creates a dependency.
  function automatic logic raw_match(input logic [REG_ADDR_W-1:0] dest,
                                     input logic [REG_ADDR_W-1:0] src1,
                                     input logic [REG_ADDR_W-1:0] src2,
                                     input logic                  uses_src2);
    return (dest != '0) && ((dest == src1) || (uses_src2 && (dest == src2)));
  endfunction

  // True when a later stage's pending write should replace an operand.
  function automatic logic fwd_hit(input logic                  wr_en,
                                   input logic [REG_ADDR_W-1:0] dest,
                                   input logic [REG_ADDR_W-1:0] src);
    return wr_en && (dest != '0) && (dest == src);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: ID-stage instruction fields, MEM/WB result taps, flush
// in; stall, EX operands/control and stall counter out.
// master = surrounding pipeline (drives id_*/mem_*/wb_*/flush), slave = id_ex_stage.
interface id_ex_stage_if
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int CMD_W  = mips_pkg::CMD_W
);

  logic                  flush;

  logic                  id_valid;
  logic                  id_wb_en;
  logic                  id_mem_r;
  logic                  id_mem_w;
  logic                  id_uses_src2;
  logic [REG_ADDR_W-1:0] id_src1;
  logic [REG_ADDR_W-1:0] id_src2;
  logic [REG_ADDR_W-1:0] id_dest;
  logic [DATA_W-1:0]     id_reg1;
  logic [DATA_W-1:0]     id_reg2;
  logic [DATA_W-1:0]     id_imm;
  logic [DATA_W-1:0]     id_pc;
  logic [CMD_W-1:0]      id_alu_cmd;

  logic [REG_ADDR_W-1:0] mem_dest;
  logic                  mem_wb_en;
  logic [DATA_W-1:0]     mem_alu_res;

  logic [REG_ADDR_W-1:0] wb_dest;
  logic                  wb_en;
  logic [DATA_W-1:0]     wb_val;

  logic                  stall;
  logic                  ex_valid;
  logic                  ex_wb_en;
  logic                  ex_mem_r;
  logic                  ex_mem_w;
  logic [REG_ADDR_W-1:0] ex_dest;
  logic [CMD_W-1:0]      ex_alu_cmd;
  logic [DATA_W-1:0]     ex_pc;
  logic [DATA_W-1:0]     ex_imm;
  logic [DATA_W-1:0]     ex_val1;
  logic [DATA_W-1:0]     ex_val2;
  logic [31:0]           stall_cnt;

  modport master (
    output flush,
    output id_valid, id_wb_en, id_mem_r, id_mem_w, id_uses_src2,
    output id_src1, id_src2, id_dest, id_reg1, id_reg2, id_imm, id_pc, id_alu_cmd,
    output mem_dest, mem_wb_en, mem_alu_res,
    output wb_dest, wb_en, wb_val,
    input  stall, ex_valid, ex_wb_en, ex_mem_r, ex_mem_w, ex_dest, ex_alu_cmd,
    input  ex_pc, ex_imm, ex_val1, ex_val2, stall_cnt
  );

  modport slave (
    input  flush,
    input  id_valid, id_wb_en, id_mem_r, id_mem_w, id_uses_src2,
    input  id_src1, id_src2, id_dest, id_reg1, id_reg2, id_imm, id_pc, id_alu_cmd,
    input  mem_dest, mem_wb_en, mem_alu_res,
    input  wb_dest, wb_en, wb_val,
    output stall, ex_valid, ex_wb_en, ex_mem_r, ex_mem_w, ex_dest, ex_alu_cmd,
    output ex_pc, ex_imm, ex_val1, ex_val2, stall_cnt
  );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Hazard detector: decides whether the ID instruction must wait a cycle.
// Latency: purely combinational. Backpressure: o_hazard feeds the stall output.
// Build option ID_EX_FWD_EN: defined -> only load-use against EX stalls;
// undefined -> any RAW against an EX or MEM writer stalls (no forwarding exists).
// Ports: i_id_* consumer fields, i_ex_* EX-stage producer, i_mem_* MEM producer, o_hazard.
module hazard_detect
  import mips_pkg::*;
(
  input  logic                  i_id_valid,
  input  logic                  i_id_uses_src2,
  input  logic [REG_ADDR_W-1:0] i_id_src1,
  input  logic [REG_ADDR_W-1:0] i_id_src2,
  input  logic                  i_ex_valid,
  input  logic                  i_ex_wb_en,
  input  logic                  i_ex_mem_r,
  input  logic [REG_ADDR_W-1:0] i_ex_dest,
  input  logic                  i_mem_wb_en,
  input  logic [REG_ADDR_W-1:0] i_mem_dest,
  output logic                  o_hazard
);

  logic w_ex_raw;
  assign w_ex_raw = i_ex_valid & i_ex_wb_en &
                    raw_match(i_ex_dest, i_id_src1, i_id_src2, i_id_uses_src2);

`ifdef ID_EX_FWD_EN
  // Only load data arrives too late to forward from EX; everything else
  // is covered by the forwarding muxes.
  assign o_hazard = i_id_valid & i_ex_mem_r & w_ex_raw;

  logic w_unused;
  assign w_unused = ^{i_mem_wb_en, i_mem_dest};
`else
  // Without forwarding the consumer must wait until the producer reaches WB,
  // where the negedge register-file write makes the ID read correct.
  logic w_mem_raw;
  assign w_mem_raw = i_mem_wb_en &
                     raw_match(i_mem_dest, i_id_src1, i_id_src2, i_id_uses_src2);
  assign o_hazard  = i_id_valid & (w_ex_raw | w_mem_raw);

  logic w_unused;
  assign w_unused = i_ex_mem_r;
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hazard stall, flush bubble and EX operand forwarding.
// Latency: ID fields appear on ex_* one cycle later; ex_val1/2 forwarding is combinational.
// Backpressure: stall freezes PC/IF-ID upstream while a bubble enters EX; flush overrides stall.
// Build option ID_EX_FWD_EN: enables MEM/WB forwarding muxes (default build has none).
// Ports: clk, rst (async, active-high), bus (id_ex_stage_if.slave).
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int CMD_W  = mips_pkg::CMD_W
)(
  input  logic         clk,
  input  logic         rst,
  id_ex_stage_if.slave bus
);

  logic                  r_valid;
  logic                  r_wb_en;
  logic                  r_mem_r;
  logic                  r_mem_w;
  logic [REG_ADDR_W-1:0] r_dest;
  logic [REG_ADDR_W-1:0] r_src1;
  logic [REG_ADDR_W-1:0] r_src2;
  logic [CMD_W-1:0]      r_alu_cmd;
  logic [DATA_W-1:0]     r_pc;
  logic [DATA_W-1:0]     r_imm;
  logic [DATA_W-1:0]     r_reg1;
  logic [DATA_W-1:0]     r_reg2;
  logic [31:0]           r_stall_cnt;

  logic                  w_hazard;
  logic                  w_stall;
  logic                  w_bubble;
  logic [DATA_W-1:0]     w_val1;
  logic [DATA_W-1:0]     w_val2;

  hazard_detect u_hazard (
    .i_id_valid     (bus.id_valid),
    .i_id_uses_src2 (bus.id_uses_src2),
    .i_id_src1      (bus.id_src1),
    .i_id_src2      (bus.id_src2),
    .i_ex_valid     (r_valid),
    .i_ex_wb_en     (r_wb_en),
    .i_ex_mem_r     (r_mem_r),
    .i_ex_dest      (r_dest),
    .i_mem_wb_en    (bus.mem_wb_en),
    .i_mem_dest     (bus.mem_dest),
    .o_hazard       (w_hazard)
  );

  // A flushed instruction is dead anyway, so holding ID for it is pointless.
  assign w_stall  = w_hazard & ~bus.flush;
  assign w_bubble = w_stall | bus.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_wb_en     <= 1'b0;
      r_mem_r     <= 1'b0;
      r_mem_w     <= 1'b0;
      r_dest      <= '0;
      r_src1      <= '0;
      r_src2      <= '0;
      r_alu_cmd   <= '0;
      r_pc        <= '0;
      r_imm       <= '0;
      r_reg1      <= '0;
      r_reg2      <= '0;
      r_stall_cnt <= '0;
    end else begin
      // Bubble only needs the side-effect controls cleared; data fields are
      // captured unconditionally since nothing consumes them when invalid.
      r_valid   <= bus.id_valid & ~w_bubble;
      r_wb_en   <= bus.id_wb_en & ~w_bubble;
      r_mem_r   <= bus.id_mem_r & ~w_bubble;
      r_mem_w   <= bus.id_mem_w & ~w_bubble;
      r_dest    <= bus.id_dest;
      r_src1    <= bus.id_src1;
      r_src2    <= bus.id_src2;
      r_alu_cmd <= bus.id_alu_cmd;
      r_pc      <= bus.id_pc;
      r_imm     <= bus.id_imm;
      r_reg1    <= bus.id_reg1;
      r_reg2    <= bus.id_reg2;
      if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

`ifdef ID_EX_FWD_EN
  // MEM holds the younger write to the same register, so it wins over WB.
  assign w_val1 = fwd_hit(bus.mem_wb_en, bus.mem_dest, r_src1) ? bus.mem_alu_res :
                  fwd_hit(bus.wb_en,     bus.wb_dest,  r_src1) ? bus.wb_val      :
                                                                 r_reg1;
  assign w_val2 = fwd_hit(bus.mem_wb_en, bus.mem_dest, r_src2) ? bus.mem_alu_res :
                  fwd_hit(bus.wb_en,     bus.wb_dest,  r_src2) ? bus.wb_val      :
                                                                 r_reg2;
`else
  assign w_val1 = r_reg1;
  assign w_val2 = r_reg2;

  logic w_unused;
  assign w_unused = ^{r_src1, r_src2, bus.mem_alu_res, bus.wb_dest, bus.wb_en, bus.wb_val};
`endif

  assign bus.stall      = w_stall;
  assign bus.ex_valid   = r_valid;
  assign bus.ex_wb_en   = r_wb_en;
  assign bus.ex_mem_r   = r_mem_r;
  assign bus.ex_mem_w   = r_mem_w;
  assign bus.ex_dest    = r_dest;
  assign bus.ex_alu_cmd = r_alu_cmd;
  assign bus.ex_pc      = r_pc;
  assign bus.ex_imm     = r_imm;
  assign bus.ex_val1    = w_val1;
  assign bus.ex_val2    = w_val2;
  assign bus.stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table for per-cycle pipeline behaviour,
// plus hand sequences for forwarding priority and reset during a stall.
// Expectations adapt to whether ID_EX_FWD_EN is defined.
module tb_id_ex_stage;
  import mips_pkg::*;

`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  typedef struct {
    bit        fl, vl, wb, mr, u2;
    bit [4:0]  s1, s2, d;
    bit [31:0] r1, r2;
    bit [4:0]  md;
    bit        mwe;
    bit [31:0] mres;
    bit [4:0]  wd;
    bit        we;
    bit [31:0] wv;
    bit        st, ev;
    bit [4:0]  ed;
    bit [31:0] v1, v2, cnt;
  } vec_t;

  task automatic idle_env();
    bus.mem_dest = '0; bus.mem_wb_en = 1'b0; bus.mem_alu_res = '0;
    bus.wb_dest  = '0; bus.wb_en     = 1'b0; bus.wb_val      = '0;
  endtask

  task automatic set_id(input bit vl, input bit wb, input bit mr, input bit u2,
                        input bit [4:0] s1, input bit [4:0] s2, input bit [4:0] d,
                        input bit [31:0] r1, input bit [31:0] r2);
    bus.id_valid = vl; bus.id_wb_en = wb; bus.id_mem_r = mr; bus.id_mem_w = 1'b0;
    bus.id_uses_src2 = u2; bus.id_src1 = s1; bus.id_src2 = s2; bus.id_dest = d;
    bus.id_reg1 = r1; bus.id_reg2 = r2;
  endtask

  vec_t v [12];

  initial begin
    // fl vl wb mr u2 | s1 s2 d | r1 r2 | md mwe mres | wd we wv || st ev ed v1 v2 cnt
    v[0]  = '{1'b0,1'b1,1'b1,1'b0,1'b1, 5'd1,5'd2,5'd3, 32'd5,32'd7,
              5'd0,1'b0,32'h0, 5'd0,1'b0,32'h0,
              1'b0,1'b1,5'd3, 32'd5,32'd7, 32'd0};
    v[1]  = '{1'b0,1'b1,1'b1,1'b1,1'b0, 5'd1,5'd0,5'd4, 32'h100,32'h0,
              5'd0,1'b0,32'h0, 5'd0,1'b0,32'h0,
              1'b0,1'b1,5'd4, 32'h100,32'h0, 32'd0};
    v[2]  = '{1'b0,1'b1,1'b1,1'b0,1'b1, 5'd4,5'd1,5'd5, 32'h0,32'd9,
              5'd0,1'b0,32'h0, 5'd0,1'b0,32'h0,
              1'b1,1'b0,5'd5, 32'h0,32'h0, 32'd1};
    v[3]  = '{1'b0,1'b1,1'b1,1'b0,1'b1, 5'd4,5'd1,5'd5, 32'h11,32'd9,
              5'd0,1'b0,32'h0, 5'd4,1'b1,32'h77,
              1'b0,1'b1,5'd5, (FWD ? 32'h77 : 32'h11),32'd9, 32'd1};
    v[4]  = '{1'b0,1'b1,1'b1,1'b1,1'b0, 5'd2,5'd0,5'd6, 32'h200,32'h0,
              5'd0,1'b0,32'h0, 5'd0,1'b0,32'h0,
              1'b0,1'b1,5'd6, 32'h200,32'h0, 32'd1};
    v[5]  = '{1'b1,1'b1,1'b1,1'b0,1'b1, 5'd6,5'd6,5'd7, 32'h1,32'h1,
              5'd0,1'b0,32'h0, 5'd0,1'b0,32'h0,
              1'b0,1'b0,5'd7, 32'h0,32'h0, 32'd1};
    v[6]  = '{1'b0,1'b1,1'b1,1'b1,1'b0, 5'd1,5'd0,5'd0, 32'h40,32'h0,
              5'd0,1'b0,32'h0, 5'd0,1'b0,32'h0,
              1'b0,1'b1,5'd0, 32'h40,32'h0, 32'd1};
    v[7]  = '{1'b0,1'b1,1'b1,1'b0,1'b1, 5'd0,5'd0,5'd8, 32'h0,32'h0,
              5'd0,1'b1,32'h55, 5'd0,1'b0,32'h0,
              1'b0,1'b1,5'd8, 32'h0,32'h0, 32'd1};
    v[8]  = '{1'b0,1'b1,1'b1,1'b0,1'b1, 5'd8,5'd1,5'd9, 32'h123,32'h5,
              5'd0,1'b0,32'h0, 5'd0,1'b0,32'h0,
              !FWD, FWD, 5'd9, 32'h123,32'h5, (FWD ? 32'd1 : 32'd2)};
    v[9]  = '{1'b0,1'b1,1'b1,1'b0,1'b1, 5'd7,5'd0,5'd6, 32'h31,32'h32,
              5'd7,1'b1,32'h99, 5'd0,1'b0,32'h0,
              !FWD, FWD, 5'd6, 32'h99,32'h32, (FWD ? 32'd1 : 32'd3)};
    v[10] = '{1'b0,1'b1,1'b1,1'b0,1'b1, 5'd1,5'd2,5'd10, 32'h1,32'h2,
              5'd0,1'b0,32'h0, 5'd0,1'b0,32'h0,
              1'b0,1'b1,5'd10, 32'h1,32'h2, (FWD ? 32'd1 : 32'd3)};
    v[11] = '{1'b0,1'b0,1'b1,1'b0,1'b1, 5'd10,5'd10,5'd11, 32'h0,32'h0,
              5'd0,1'b0,32'h0, 5'd0,1'b0,32'h0,
              1'b0,1'b0,5'd11, 32'h0,32'h0, (FWD ? 32'd1 : 32'd3)};

    // ---------------- reset state ----------------
    rst = 1'b1;
    bus.flush = 1'b0;
    set_id(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
    bus.id_imm = '0; bus.id_pc = '0; bus.id_alu_cmd = ALU_ADD;
    idle_env();
    repeat (2) @(negedge clk);
    chk("rst.ex_valid",  32'(bus.ex_valid),  32'd0);
    chk("rst.stall",     32'(bus.stall),     32'd0);
    chk("rst.stall_cnt", bus.stall_cnt,      32'd0);
    chk("rst.ex_val1",   bus.ex_val1,        32'd0);
    rst = 1'b0;

    // ---------------- vector table ----------------
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.flush = v[i].fl;
      set_id(v[i].vl, v[i].wb, v[i].mr, v[i].u2, v[i].s1, v[i].s2, v[i].d, v[i].r1, v[i].r2);
      bus.id_pc = 32'(i * 4); bus.id_imm = 32'(i + 100); bus.id_alu_cmd = 4'(i);
      bus.mem_dest = v[i].md; bus.mem_wb_en = v[i].mwe; bus.mem_alu_res = v[i].mres;
      bus.wb_dest  = v[i].wd; bus.wb_en     = v[i].we;  bus.wb_val      = v[i].wv;
      #1;
      chk($sformatf("v%0d.stall", i), 32'(bus.stall), 32'(v[i].st));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.ex_valid", i),  32'(bus.ex_valid), 32'(v[i].ev));
      chk($sformatf("v%0d.stall_cnt", i), bus.stall_cnt,     v[i].cnt);
      if (v[i].ev) begin
        chk($sformatf("v%0d.ex_dest", i),  32'(bus.ex_dest),    32'(v[i].ed));
        chk($sformatf("v%0d.ex_val1", i),  bus.ex_val1,         v[i].v1);
        chk($sformatf("v%0d.ex_val2", i),  bus.ex_val2,         v[i].v2);
        chk($sformatf("v%0d.ex_mem_r", i), 32'(bus.ex_mem_r),   32'(v[i].mr));
        chk($sformatf("v%0d.ex_pc", i),    bus.ex_pc,           32'(i * 4));
        chk($sformatf("v%0d.ex_imm", i),   bus.ex_imm,          32'(i + 100));
        chk($sformatf("v%0d.ex_cmd", i),   32'(bus.ex_alu_cmd), 32'(i));
      end
    end

    // ---------------- forwarding priority (MEM over WB, then register) ----------------
    @(negedge clk);
    bus.flush = 1'b0;
    set_id(1'b1, 1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 5'd11, 32'h10, 32'h22);
    idle_env();
    @(posedge clk);
    @(negedge clk);
    set_id(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
    bus.mem_dest = 5'd2; bus.mem_wb_en = 1'b1; bus.mem_alu_res = 32'hAA;
    bus.wb_dest  = 5'd2; bus.wb_en     = 1'b1; bus.wb_val      = 32'hBB;
    #1 chk("fwd.mem_prio", bus.ex_val2, FWD ? 32'hAA : 32'h22);
    bus.mem_wb_en = 1'b0;
    #1 chk("fwd.wb",       bus.ex_val2, FWD ? 32'hBB : 32'h22);
    bus.wb_en = 1'b0;
    #1 chk("fwd.none",     bus.ex_val2, 32'h22);
    bus.mem_dest = 5'd1; bus.mem_wb_en = 1'b1;
    #1 chk("fwd.src1",     bus.ex_val1, FWD ? 32'hAA : 32'h10);
    idle_env();

    // ---------------- reset pulse during a load-use stall ----------------
    @(negedge clk);
    set_id(1'b1, 1'b1, 1'b1, 1'b0, 5'd1, 5'd0, 5'd4, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    set_id(1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 5'd1, 5'd5, 32'h66, 32'h3);
    #1 chk("rstmid.stall_before", 32'(bus.stall), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid.ex_valid",  32'(bus.ex_valid), 32'd0);
    chk("rstmid.stall_cnt", bus.stall_cnt,     32'd0);
    chk("rstmid.stall",     32'(bus.stall),    32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rstmid.cap_valid", 32'(bus.ex_valid), 32'd1);
    chk("rstmid.cap_dest",  32'(bus.ex_dest),  32'd5);
    chk("rstmid.cap_val1",  bus.ex_val1,       32'h66);
    chk("rstmid.cnt_after", bus.stall_cnt,     32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
